// File: rtl/quad_step_decoder.sv
// Quadrature front end: per-channel synchroniser, run-length glitch filter and
// Gray-code step decoder producing registered inc/dec/err pulses.
module quad_step_decoder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_in,
  input  logic b_in,
  output logic inc,
  output logic dec,
  output logic err
);

  localparam int unsigned FCW = $clog2(FILT_LEN + 1);
  localparam int unsigned ICW = $clog2(SYNC_STAGES + 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                 state_q, state_d;
  logic [ICW-1:0]         init_cnt_q, init_cnt_d;
  logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q;
  logic                   a_s, b_s;
  logic                   a_f_q, a_f_d, b_f_q, b_f_d;
  logic [FCW-1:0]         a_fc_q, a_fc_d, b_fc_q, b_fc_d;
  logic [1:0]             prev_q, prev_d;
  logic [1:0]             cur, step;
  logic                   inc_q, inc_d, dec_q, dec_d, err_q, err_d;

  // Gray code to linear position: 00->0, 01->1, 11->2, 10->3.
  function automatic logic [1:0] gray_pos(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  assign a_s  = a_sync_q[SYNC_STAGES-1];
  assign b_s  = b_sync_q[SYNC_STAGES-1];
  assign cur  = {a_f_q, b_f_q};
  assign step = gray_pos(cur) - gray_pos(prev_q);

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    a_f_d      = a_f_q;
    b_f_d      = b_f_q;
    a_fc_d     = a_fc_q;
    b_fc_d     = b_fc_q;
    prev_d     = prev_q;
    inc_d      = 1'b0;
    dec_d      = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        // One extra cycle beyond the chain depth so the adopted level is the
        // real pin level rather than the cleared synchroniser contents.
        if (init_cnt_q == ICW'(SYNC_STAGES)) begin
          state_d = ST_RUN;
          a_f_d   = a_s;
          b_f_d   = b_s;
          prev_d  = {a_s, b_s};
          a_fc_d  = '0;
          b_fc_d  = '0;
        end else begin
          init_cnt_d = init_cnt_q + ICW'(1);
        end
      end
      ST_RUN: begin
        if (a_s == a_f_q) begin
          a_fc_d = '0;
        end else if (a_fc_q == FCW'(FILT_LEN - 1)) begin
          a_f_d  = a_s;
          a_fc_d = '0;
        end else begin
          a_fc_d = a_fc_q + FCW'(1);
        end

        if (b_s == b_f_q) begin
          b_fc_d = '0;
        end else if (b_fc_q == FCW'(FILT_LEN - 1)) begin
          b_f_d  = b_s;
          b_fc_d = '0;
        end else begin
          b_fc_d = b_fc_q + FCW'(1);
        end

        prev_d = cur;
        inc_d  = (step == 2'd1);
        dec_d  = (step == 2'd3);
        err_d  = (step == 2'd2);
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      a_sync_q   <= '0;
      b_sync_q   <= '0;
      a_f_q      <= 1'b0;
      b_f_q      <= 1'b0;
      a_fc_q     <= '0;
      b_fc_q     <= '0;
      prev_q     <= '0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      a_sync_q   <= {a_sync_q[SYNC_STAGES-2:0], a_in};
      b_sync_q   <= {b_sync_q[SYNC_STAGES-2:0], b_in};
      a_f_q      <= a_f_d;
      b_f_q      <= b_f_d;
      a_fc_q     <= a_fc_d;
      b_fc_q     <= b_fc_d;
      prev_q     <= prev_d;
      inc_q      <= inc_d;
      dec_q      <= dec_d;
      err_q      <= err_d;
    end
  end

  assign inc = inc_q;
  assign dec = dec_q;
  assign err = err_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: per-cycle comparison against a history-window
// model, a level/hold vector table, hand-written corner sequences and random holds.
module tb_quad_step_decoder;

  localparam int unsigned SYNC = 2;
  localparam int unsigned FILT = 4;
  localparam int          HMAX = 16384;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_in = 1'b0;
  logic b_in = 1'b0;
  logic inc, dec, err;

  quad_step_decoder #(.SYNC_STAGES(SYNC), .FILT_LEN(FILT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a_in (a_in),
    .b_in (b_in),
    .inc  (inc),
    .dec  (dec),
    .err  (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cnt_inc = 0, cnt_dec = 0, cnt_err = 0;

  // Reference model: raw pin history per edge; a filtered value flips when the
  // last FILT synchronised samples (all after start-up) disagree with it.
  bit   a_hist [HMAX];
  bit   b_hist [HMAX];
  int   edge_n = 0;
  int   rst_e  = 0;
  int   exit_e = 0;
  bit   m_af = 1'b0, m_bf = 1'b0;
  bit [1:0] m_prev = 2'b00;
  bit   exp_inc = 1'b0, exp_dec = 1'b0, exp_err = 1'b0;

  function automatic bit [1:0] fwd(input bit [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic bit window_differs(input bit ch_b, input bit level, input int n);
    for (int j = 0; j < int'(FILT); j++) begin
      int idx;
      bit smp;
      idx = n - j - int'(SYNC);
      smp = ch_b ? b_hist[idx] : a_hist[idx];
      if (smp == level) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit [1:0] cur;
    bit       na, nb;
    a_hist[edge_n] = a_in;
    b_hist[edge_n] = b_in;
    exp_inc = 1'b0;
    exp_dec = 1'b0;
    exp_err = 1'b0;
    if (!rst_n) begin
      rst_e  = edge_n;
      exit_e = edge_n + int'(SYNC) + 1;
      m_af   = 1'b0;
      m_bf   = 1'b0;
      m_prev = 2'b00;
    end else if (edge_n == exit_e) begin
      m_af   = a_hist[rst_e + 1];
      m_bf   = b_hist[rst_e + 1];
      m_prev = {m_af, m_bf};
    end else if (edge_n > exit_e) begin
      cur = {m_af, m_bf};
      if (cur != m_prev) begin
        if (cur == fwd(m_prev))      exp_inc = 1'b1;
        else if (m_prev == fwd(cur)) exp_dec = 1'b1;
        else                         exp_err = 1'b1;
      end
      m_prev = cur;
      if (edge_n - int'(FILT) + 1 > exit_e) begin
        na = window_differs(1'b0, m_af, edge_n);
        nb = window_differs(1'b1, m_bf, edge_n);
        if (na) m_af = ~m_af;
        if (nb) m_bf = ~m_bf;
      end
    end
    edge_n++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    checks++;
    if ({inc, dec, err} !== {exp_inc, exp_dec, exp_err}) begin
      errors++;
      $display("FAIL model_cycle edge=%0d got inc/dec/err=%b%b%b want %b%b%b",
               edge_n - 1, inc, dec, err, exp_inc, exp_dec, exp_err);
    end
    if (inc === 1'b1) cnt_inc++;
    if (dec === 1'b1) cnt_dec++;
    if (err === 1'b1) cnt_err++;
  endtask

  task automatic hold(input bit a, input bit b, input int n);
    a_in = a;
    b_in = b;
    repeat (n) cyc();
  endtask

  task automatic clear_counts();
    cnt_inc = 0;
    cnt_dec = 0;
    cnt_err = 0;
  endtask

  task automatic expect_counts(input string name, input int ei, input int ed, input int ee);
    checks++;
    if (cnt_inc != ei || cnt_dec != ed || cnt_err != ee) begin
      errors++;
      $display("FAIL %s got inc=%0d dec=%0d err=%0d want inc=%0d dec=%0d err=%0d",
               name, cnt_inc, cnt_dec, cnt_err, ei, ed, ee);
    end
  endtask

  task automatic expect_eq(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  typedef struct {
    bit a;
    bit b;
    int hold_cycles;
    int n_inc;
    int n_dec;
    int n_err;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int first;

    vecs[0] = '{1'b0, 1'b1, 10, 1, 0, 0};
    vecs[1] = '{1'b1, 1'b1, 10, 1, 0, 0};
    vecs[2] = '{1'b1, 1'b0, 10, 1, 0, 0};
    vecs[3] = '{1'b0, 1'b0, 10, 1, 0, 0};
    vecs[4] = '{1'b1, 1'b0, 10, 0, 1, 0};
    vecs[5] = '{1'b1, 1'b1, 10, 0, 1, 0};
    vecs[6] = '{1'b0, 1'b1, 10, 0, 1, 0};
    vecs[7] = '{1'b0, 1'b0, 10, 0, 1, 0};

    // Start-up at position 11: adopted silently.
    rst_n = 1'b0;
    hold(1'b1, 1'b1, 3);
    rst_n = 1'b1;
    clear_counts();
    hold(1'b1, 1'b1, 20);
    expect_counts("startup_quiet", 0, 0, 0);
    clear_counts();
    hold(1'b0, 1'b1, 12);
    expect_counts("a_fall_dec", 0, 1, 0);
    hold(1'b0, 1'b0, 12);

    // Latency of the first forward step from 00.
    clear_counts();
    first = -1;
    a_in = 1'b0;
    b_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (inc === 1'b1 && first < 0) first = i;
    end
    expect_eq("inc_latency_edge", first, 6);
    expect_counts("latency_step", 1, 0, 0);
    hold(1'b0, 1'b0, 10);

    // Forward then reverse rotation from the table.
    for (int i = 0; i < 8; i++) begin
      clear_counts();
      hold(vecs[i].a, vecs[i].b, vecs[i].hold_cycles);
      expect_counts($sformatf("vec%0d", i), vecs[i].n_inc, vecs[i].n_dec, vecs[i].n_err);
    end

    // Glitch rejection and minimum accepted pulse.
    clear_counts();
    hold(1'b0, 1'b1, 3);
    hold(1'b0, 1'b0, 12);
    expect_counts("glitch3_rejected", 0, 0, 0);
    clear_counts();
    hold(1'b0, 1'b1, 4);
    hold(1'b0, 1'b0, 14);
    expect_counts("pulse4_accepted", 1, 1, 0);

    // Simultaneous change 00->11.
    clear_counts();
    first = -1;
    a_in = 1'b1;
    b_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (err === 1'b1 && first < 0) first = i;
    end
    expect_eq("err_latency_edge", first, 6);
    expect_counts("double_change_err", 0, 0, 1);
    clear_counts();
    hold(1'b1, 1'b0, 12);
    expect_counts("after_err_inc", 1, 0, 0);
    hold(1'b0, 1'b0, 12);

    // Reset in the middle of forward rotation.
    hold(1'b0, 1'b1, 10);
    hold(1'b1, 1'b1, 8);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    clear_counts();
    repeat (SYNC + 1) cyc();
    expect_counts("init_quiet", 0, 0, 0);
    hold(1'b1, 1'b1, 6);
    expect_counts("reset_level_adopted", 0, 0, 0);
    clear_counts();
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 10);
    hold(1'b0, 1'b1, 10);
    expect_counts("resume_after_reset", 3, 0, 0);

    // Random levels and holds with occasional reset pulses.
    for (int s = 0; s < 220; s++) begin
      if ($urandom_range(0, 99) < 3) begin
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
      end
      hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
    end
    hold(a_in, b_in, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout edge=%0d", edge_n);
    $fatal(1, "timeout");
  end

endmodule
